// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath definitions: branch-unit FSM states and NZP condition-code encodings.
package lc3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    REDIR = 2'd2
  } pcb_state_t;

  localparam logic [2:0] CC_N     = 3'b100;
  localparam logic [2:0] CC_Z     = 3'b010;
  localparam logic [2:0] CC_P     = 3'b001;
  localparam logic [2:0] CC_RESET = CC_Z;

endpackage

// File: rtl/cc_gen.sv
// Combinational NZP generator: classifies a 16-bit two's-complement value as negative, zero or positive.
module cc_gen
  import lc3_pkg::*;
(
  input  logic [15:0] value,
  output logic [2:0]  nzp
);

  always_comb begin
    if (value[15])
      nzp = CC_N;
    else if (value == 16'h0000)
      nzp = CC_Z;
    else
      nzp = CC_P;
  end

endmodule

// File: rtl/pc_branch_unit.sv
// PC and NZP holder that resolves conditional branches and redirects fetch to PC + offset.
// Optional taken-branch statistics counter is built only when PCB_STATS_EN is defined.
module pc_branch_unit
  import lc3_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        pc_inc,
  input  logic        ld_cc,
  input  logic [15:0] bus_in,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [2:0]  br_nzp,
  input  logic [15:0] br_sext,
  output logic [15:0] pc_out,
  output logic [2:0]  cc_nzp,
  output logic        redirect,
  output logic [15:0] target,
  output logic [15:0] br_taken_cnt
);

  pcb_state_t  state_reg;
  logic [15:0] pc_reg;
  logic [15:0] target_reg;
  logic [15:0] sext_reg;
  logic [2:0]  nzp_reg;
  logic [2:0]  cc_reg;
  logic        redirect_reg;

  logic [2:0]  cc_next;
  logic [15:0] sum_next;
  logic        taken;

  cc_gen u_cc_gen (
    .value (bus_in),
    .nzp   (cc_next)
  );

  // Modulo-2^16 add; the same sum feeds both the target register and the PC.
  assign sum_next = pc_reg + sext_reg;
  assign taken    = |(nzp_reg & cc_reg);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      target_reg   <= 16'h0000;
      sext_reg     <= 16'h0000;
      nzp_reg      <= 3'b000;
      cc_reg       <= CC_RESET;
      redirect_reg <= 1'b0;
    end else begin
      redirect_reg <= 1'b0;
      // CC loads are independent of the FSM; in EVAL the branch still sees the old value.
      if (ld_cc)
        cc_reg <= cc_next;
      case (state_reg)
        IDLE: begin
          if (pc_inc)
            pc_reg <= pc_reg + 16'd1;
          if (br_valid) begin
            nzp_reg   <= br_nzp;
            sext_reg  <= br_sext;
            state_reg <= EVAL;
          end
        end
        EVAL: begin
          target_reg <= sum_next;
          if (taken) begin
            pc_reg       <= sum_next;
            redirect_reg <= 1'b1;
            state_reg    <= REDIR;
          end else begin
            state_reg <= IDLE;
          end
        end
        REDIR: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef PCB_STATS_EN
  logic [15:0] taken_cnt_reg;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      taken_cnt_reg <= 16'h0000;
    else if (state_reg == EVAL && taken && taken_cnt_reg != 16'hFFFF)
      taken_cnt_reg <= taken_cnt_reg + 16'd1;
  end

  assign br_taken_cnt = taken_cnt_reg;
`else
  assign br_taken_cnt = 16'h0000;
`endif

  assign br_ready = (state_reg == IDLE);
  assign pc_out   = pc_reg;
  assign cc_nzp   = cc_reg;
  assign redirect = redirect_reg;
  assign target   = target_reg;

endmodule
